// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter between instruction fetch and load/store.
// Serialises 1/2/4-byte transactions and assembles little-endian words.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_abort,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
    logic [7:0]          ram_dout_q, ram_dout_d;
    logic                ram_wr_q, ram_wr_d;
    logic                if_done_q, if_done_d;
    logic                mem_done_q, mem_done_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

    logic [CNT_W-1:0]    next_k;
    logic [1:0]          byte_idx;

    function automatic logic [CNT_W-1:0] len_to_n(input logic [1:0] len);
        case (len)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // cnt counts edges since accept; read byte k lands on the edge where cnt == k+1
    assign next_k   = cnt_q + 3'd1;
    assign byte_idx = 2'(cnt_q - 3'd1);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        ram_a_d     = '0;
        ram_dout_d  = '0;
        ram_wr_d    = 1'b0;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            ST_IDLE: begin
                // the done cycle blocks acceptance while the requester drops req
                if (!if_done_q && !mem_done_q) begin
                    if (mem_req) begin
                        owner_d = OWN_MEM;
                        base_d  = mem_addr;
                        wdata_d = mem_wdata;
                        n_d     = len_to_n(mem_len);
                        cnt_d   = '0;
                        buf_d   = '0;
                        ram_a_d = mem_addr;
                        if (mem_we) begin
                            state_d    = ST_WR;
                            ram_dout_d = mem_wdata[7:0];
                            ram_wr_d   = 1'b1;
                        end else begin
                            state_d = ST_RD;
                        end
                    end else if (if_req && !if_abort) begin
                        owner_d = OWN_IF;
                        base_d  = if_addr;
                        n_d     = 3'd4;
                        cnt_d   = '0;
                        buf_d   = '0;
                        ram_a_d = if_addr;
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (owner_q == OWN_IF && if_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = next_k;
                    if (cnt_q != '0) begin
                        buf_d[{byte_idx, 3'b000} +: 8] = ram_din;
                    end
                    if (next_k < n_q) begin
                        ram_a_d = base_q + ADDR_W'(next_k);
                    end
                    if (cnt_q == n_q) begin
                        state_d = ST_IDLE;
                        if (owner_q == OWN_IF) begin
                            if_done_d = 1'b1;
                            if_data_d = buf_d;
                        end else begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = buf_d;
                        end
                    end
                end
            end
            ST_WR: begin
                cnt_d = next_k;
                if (next_k < n_q) begin
                    ram_a_d    = base_q + ADDR_W'(next_k);
                    ram_dout_d = wdata_q[{next_k[1:0], 3'b000} +: 8];
                    ram_wr_d   = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                    mem_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // reset wins over rdy_in; rdy_in low freezes every register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            n_q         <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    assign ram_wr    = ram_wr_q;
    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-schedule model checked every cycle,
// directed scenarios with literal expectations, stalling byte RAM.
module tb_mem_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        if_req, if_abort, if_done;
    logic [31:0] if_addr, if_data;
    logic        mem_req, mem_we, mem_done;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  ram_din = 8'h00;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int if_done_cnt = 0;

    logic [7:0] ram_mem [bit [31:0]];

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
        .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] ram_peek(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] expect_word(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = ram_peek(a + 32'(k));
        return w;
    endfunction

    // byte RAM: read data one cycle after address, stalls with rdy_in
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (rst_in && rdy_in) begin
            ram_din <= ram_peek(ram_a);
            if (ram_wr) ram_mem[ram_a] = ram_dout;
        end
    end

    // transaction-level model: one active transaction with its cycle age
    bit          started = 0;
    bit          m_busy = 0, m_rd = 0, m_if_owner = 0;
    bit          m_if_done = 0, m_mem_done = 0, m_can_acc = 0;
    int          m_age = 0, m_n = 0, m_end = 0;
    logic [31:0] m_base = '0, m_wdata = '0, m_word = '0;
    logic [31:0] m_if_data = '0, m_mem_rdata = '0;

    always @(posedge clk_in) begin
        started = 1;
        if (!rst_in) begin
            m_busy = 0; m_if_done = 0; m_mem_done = 0;
            m_if_data = '0; m_mem_rdata = '0;
        end else if (rdy_in) begin
            m_can_acc = !m_if_done && !m_mem_done && !m_busy;
            m_if_done = 0;
            m_mem_done = 0;
            if (m_busy) begin
                if (m_rd && m_if_owner && if_abort) begin
                    m_busy = 0;
                end else begin
                    m_age++;
                    if (m_age == m_end) begin
                        m_busy = 0;
                        if (m_if_owner) begin
                            m_if_done = 1; m_if_data = m_word;
                        end else begin
                            m_mem_done = 1;
                            if (m_rd) m_mem_rdata = m_word;
                        end
                    end
                end
            end else if (m_can_acc) begin
                if (mem_req) begin
                    m_busy = 1; m_age = 1; m_if_owner = 0; m_rd = !mem_we;
                    m_base = mem_addr; m_wdata = mem_wdata;
                    m_n = (mem_len == 2'd0) ? 1 : (mem_len == 2'd1) ? 2 : 4;
                    m_end = m_rd ? m_n + 2 : m_n + 1;
                    m_word = m_rd ? expect_word(mem_addr, m_n) : '0;
                end else if (if_req && !if_abort) begin
                    m_busy = 1; m_age = 1; m_if_owner = 1; m_rd = 1;
                    m_base = if_addr; m_n = 4; m_end = 6;
                    m_word = expect_word(if_addr, 4);
                end
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk_in) begin
        if (started) begin
            if (if_done === 1'b1) if_done_cnt++;
            chk("if_done", 32'(if_done), 32'(m_if_done));
            chk("mem_done", 32'(mem_done), 32'(m_mem_done));
            chk("if_data", if_data, m_if_data);
            chk("mem_rdata", mem_rdata, m_mem_rdata);
            if (!m_busy) begin
                chk("idle_ram_wr", 32'(ram_wr), 32'd0);
                chk("idle_ram_a", ram_a, 32'd0);
                chk("idle_ram_dout", 32'(ram_dout), 32'd0);
            end else if (m_age <= m_n) begin
                chk("ram_a", ram_a, m_base + 32'(m_age - 1));
                chk("ram_wr", 32'(ram_wr), m_rd ? 32'd0 : 32'd1);
                if (!m_rd) chk("ram_dout", 32'(ram_dout), 32'(m_wdata[8*(m_age-1) +: 8]));
            end
        end
    end

    task automatic wait_done(input bit want_mem, input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!((want_mem ? mem_done : if_done) === 1'b1) && n < maxc);
    endtask

    int n;
    int base_cnt;
    bit got;

    initial begin
        rst_in = 0; rdy_in = 1; if_req = 1; if_addr = 32'h100; if_abort = 0;
        mem_req = 0; mem_we = 0; mem_len = 2'd0; mem_addr = '0; mem_wdata = '0;
        ram_mem[32'h100] = 8'h13; ram_mem[32'h101] = 8'h05;
        ram_mem[32'h102] = 8'h10; ram_mem[32'h103] = 8'h00;
        ram_mem[32'h200] = 8'h11; ram_mem[32'h201] = 8'h22;
        ram_mem[32'h202] = 8'h33; ram_mem[32'h203] = 8'h44;
        ram_mem[32'h300] = 8'hAA; ram_mem[32'h301] = 8'hBB;
        ram_mem[32'h302] = 8'hCC; ram_mem[32'h303] = 8'hDD;
        ram_mem[32'h2000] = 8'h80;

        // reset held for two edges with a fetch pending
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        rst_in = 1;

        // word fetch accepted on the first edge out of reset
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk_in);
            n++;
            if (n == 1) chk("fetch_a0", ram_a, 32'h100);
            if (n == 4) chk("fetch_a3", ram_a, 32'h103);
            got = (if_done === 1'b1);
        end
        chk("fetch_latency", n, 32'd6);
        chk("fetch_data", if_data, 32'h00100513);
        if_req = 0;
        repeat (2) @(negedge clk_in);

        // simultaneous requests: MEM byte load first, then IF
        mem_req = 1; mem_we = 0; mem_len = 2'd0; mem_addr = 32'h2000;
        if_req = 1; if_addr = 32'h200;
        wait_done(1, 20, n);
        chk("sim_mem_latency", n, 32'd3);
        chk("sim_mem_rdata", mem_rdata, 32'h00000080);
        mem_req = 0;
        wait_done(0, 20, n);
        chk("sim_if_latency", n, 32'd7);
        chk("sim_if_data", if_data, 32'h44332211);
        if_req = 0;
        repeat (2) @(negedge clk_in);

        // half store wrapping the top of the address space
        mem_req = 1; mem_we = 1; mem_len = 2'd1; mem_addr = 32'hFFFF_FFFF; mem_wdata = 32'hABCD1234;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk_in);
            n++;
            if (n == 1) begin
                chk("st_wr0", 32'(ram_wr), 32'd1);
                chk("st_a0", ram_a, 32'hFFFF_FFFF);
                chk("st_d0", 32'(ram_dout), 32'h34);
            end
            if (n == 2) begin
                chk("st_wr1", 32'(ram_wr), 32'd1);
                chk("st_a1", ram_a, 32'h0);
                chk("st_d1", 32'(ram_dout), 32'h12);
            end
            got = (mem_done === 1'b1);
        end
        chk("st_latency", n, 32'd3);
        chk("st_wr_done", 32'(ram_wr), 32'd0);
        mem_req = 0;
        @(negedge clk_in);
        chk("st_wr_after", 32'(ram_wr), 32'd0);
        chk("st_mem_top", 32'(ram_peek(32'hFFFF_FFFF)), 32'h34);
        chk("st_mem_zero", 32'(ram_peek(32'h0)), 32'h12);
        @(negedge clk_in);

        // half load back across the wrap, upper bytes zeroed
        mem_req = 1; mem_we = 0; mem_len = 2'd1; mem_addr = 32'hFFFF_FFFF;
        wait_done(1, 20, n);
        chk("ldh_latency", n, 32'd4);
        chk("ldh_rdata", mem_rdata, 32'h00001234);
        mem_req = 0;
        repeat (2) @(negedge clk_in);

        // fetch aborted in cycle 3, pending word load then served
        base_cnt = if_done_cnt;
        if_req = 1; if_addr = 32'h300;
        repeat (3) @(negedge clk_in);
        if_abort = 1; if_req = 0;
        mem_req = 1; mem_we = 0; mem_len = 2'd2; mem_addr = 32'h200;
        @(negedge clk_in);
        if_abort = 0;
        chk("abort_idle_ram_a", ram_a, 32'd0);
        wait_done(1, 20, n);
        chk("abort_mem_latency", n, 32'd6);
        chk("abort_mem_rdata", mem_rdata, 32'h44332211);
        mem_req = 0;
        repeat (8) @(negedge clk_in);
        chk("abort_no_if_done", if_done_cnt - base_cnt, 32'd0);
        chk("abort_if_data_kept", if_data, 32'h44332211);

        // freeze for three cycles during a word load
        mem_req = 1; mem_we = 0; mem_len = 2'd2; mem_addr = 32'h100;
        n = 0; got = 0;
        while (!got && n < 30) begin
            @(negedge clk_in);
            n++;
            if (n == 2) begin
                chk("frz_a_before", ram_a, 32'h101);
                rdy_in = 0;
            end
            if (n >= 3 && n <= 5) begin
                chk("frz_a_held", ram_a, 32'h101);
                chk("frz_wr_held", 32'(ram_wr), 32'd0);
            end
            if (n == 5) rdy_in = 1;
            got = (mem_done === 1'b1);
        end
        chk("frz_latency", n, 32'd9);
        chk("frz_rdata", mem_rdata, 32'h00100513);
        mem_req = 0;
        repeat (3) @(negedge clk_in);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
